hub75_bcm_driver: RTL and testbench
===================================

// Module: hub75_bcm_driver
// PURPOSE
//  Parametrised HUB75 LED-matrix scan driver using binary-code modulation (BCM) over N bit planes.
//  Reads two half-panel pixel RAMs and shifts one row per plane into the panel, then latches it.
//  Shows each plane for a weighted time, gated by a global brightness value.
//  Sits between the dual frame-buffer RAMs and the panel level-shift buffers.
//  Pulses frameDone so external logic can swap buffers.
// PARAMETERS
//  COLS           64   columns per row; power of 2, >=2
//  ROW_ADDR_W     5    rowDecoder width; 2**ROW_ADDR_W scan rows per half-panel
//  BPC            2    bits per colour channel (= number of BCM planes), 1..8
//  BASE_TICKS     150  clk cycles in the plane-0 display window
//  RAM_LATENCY    2    clk cycles from pixelAddress change to valid pixel data, >=1
//  INVERT_OUTPUTS 1    1: every panel-side output is driven inverted (external buffers invert)
// PORTS
//  clk            in   1                      system clock
//  rst            in   1                      async reset, active-high
//  enable         in   1                      run scanning; sampled at frame boundary only
//  brightness     in   8                      global dimming; 0 = dark, 255 = full
//  pixelAddress0  out  ROW_ADDR_W+log2(COLS)  top-half RAM address = row*COLS+col
//  pixel0         in   3*BPC                  top-half pixel {R[BPC],G[BPC],B[BPC]}, MSB-first fields
//  pixelAddress1  out  ROW_ADDR_W+log2(COLS)  bottom-half RAM address, always equal to pixelAddress0
//  pixel1         in   3*BPC                  bottom-half pixel, same format
//  rowDecoder     out  ROW_ADDR_W             displayed scan row
//  pixelClk       out  1                      shift clock
//  columnPixels0  out  3                      {R,G,B} bit of current plane, top half
//  columnPixels1  out  3                      {R,G,B} bit of current plane, bottom half
//  columnLatch    out  1                      row latch strobe
//  blank          out  1                      output disable (1 = dark)
//  frameDone      out  1                      1-cycle pulse: all planes of all rows shown
// BEHAVIOUR
//  - Levels below are logical. Physical pin = logical ^ INVERT_OUTPUTS, for all panel outputs.
//  - Reset (async, any state): state=IDLE; row=0, col=0, plane=0.
//    Logical outputs: blank=1, pixelClk=0, columnLatch=0, columnPixels*=0, rowDecoder=0,
//    pixelAddress*=0, frameDone=0.
//  - States: IDLE, FETCH, SHIFT_HI, SHIFT_LO, LATCH, DISPLAY, NEXT_ROW, NEXT_PLANE.
//  - IDLE: blank=1. Goes to FETCH when enable=1.
//  - FETCH: drives address row*COLS+col, holds it for RAM_LATENCY cycles, then goes to SHIFT_HI.
//  - SHIFT_HI (1 cycle): columnPixelsN[2:0] = {R[plane],G[plane],B[plane]} of pixelN; pixelClk=1.
//  - SHIFT_LO (1 cycle): pixelClk=0; data held. col++.
//    If col wraps to 0 -> LATCH, else -> FETCH. Each column costs RAM_LATENCY+2 cycles.
//  - LATCH (1 cycle): columnLatch=1, blank=1.
//    rowDecoder<=row (updates only here, while blank).
//    brightness is captured here; it is stable for the whole window. Window counter is cleared.
//  - DISPLAY: window length W = BASE_TICKS<<plane cycles.
//    Lit length L = (W*(brightness+1))>>8, using a full-width product (no truncation).
//    blank=0 while counter<L, else blank=1. After W cycles -> NEXT_ROW.
//  - NEXT_ROW (1 cycle, blank=1): row++. If row wraps to 0 -> NEXT_PLANE, else -> FETCH.
//  - NEXT_PLANE (1 cycle, blank=1): plane++.
//    If plane==BPC-1 before increment: plane<=0, frameDone=1 this cycle,
//    then go to FETCH if enable=1, else IDLE.
//  - enable=0 mid-frame does not stop scanning; the frame completes first.
//  - brightness=0 -> L=0 (dark). brightness=255 -> L=W.
//  - blank is 1 in every state except DISPLAY-lit; the panel is never lit while shifting or latching.
//  - Plane scan order: plane-major (all rows of plane 0, then all rows of plane 1, ...).
// TESTING (COLS=4, ROW_ADDR_W=1, BPC=2, BASE_TICKS=4, RAM_LATENCY=2, INVERT_OUTPUTS=1)
//  1. rst=1 at any time -> physical blank=0, pixelClk=1, columnLatch=1, columnPixels*=3'b111,
//     rowDecoder=1'b1, frameDone=0. Hold enable=0 -> stays IDLE.
//  2. enable=1, RAM returns pixel=addr -> addresses 0,1,2,3 per row; 4 pixelClk pulses in 16 cycles;
//     1 latch; rowDecoder changes only in the latch cycle.
//  3. pixel0=6'b10_01_11, brightness=255 -> plane0 shifts RGB=011, lit 4 cycles;
//     plane1 shifts RGB=101, lit 8 cycles.
//  4. brightness=0 -> blank never deasserts.
//     brightness=127 -> plane0 lit 2 of 4 cycles, plane1 lit 4 of 8 cycles.
//  5. Continuous run -> exactly one frameDone pulse per 2 rows x 2 planes.
//     enable dropped mid-frame -> frame finishes, frameDone pulses, then IDLE with blank held.
//  6. rst asserted during SHIFT_HI -> outputs reach reset values with no clk edge.
//     After release, scan restarts at address 0, plane 0.

Source files
------------

// File: rtl/hub75_bcm_driver.sv
// HUB75 scan driver: shifts one row per BCM bit plane, latches it, then shows it for a
// plane-weighted window dimmed by a global brightness. Panel-side pins optionally inverted.
module hub75_bcm_driver #(
  parameter int COLS           = 64,
  parameter int ROW_ADDR_W     = 5,
  parameter int BPC            = 2,
  parameter int BASE_TICKS     = 150,
  parameter int RAM_LATENCY    = 2,
  parameter int INVERT_OUTPUTS = 1
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  enable,
  input  logic [7:0]                            brightness,
  output logic [ROW_ADDR_W+$clog2(COLS)-1:0]    pixelAddress0,
  input  logic [3*BPC-1:0]                      pixel0,
  output logic [ROW_ADDR_W+$clog2(COLS)-1:0]    pixelAddress1,
  input  logic [3*BPC-1:0]                      pixel1,
  output logic [ROW_ADDR_W-1:0]                 rowDecoder,
  output logic                                  pixelClk,
  output logic [2:0]                            columnPixels0,
  output logic [2:0]                            columnPixels1,
  output logic                                  columnLatch,
  output logic                                  blank,
  output logic                                  frameDone
);
  localparam int COL_W   = $clog2(COLS);
  localparam int ADDR_W  = ROW_ADDR_W + COL_W;
  localparam int PLANE_W = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int FCNT_W  = $clog2(RAM_LATENCY + 1);
  localparam int WIN_W   = $clog2(BASE_TICKS + 1) + BPC;
  localparam int PROD_W  = WIN_W + 9;
  localparam logic INV   = (INVERT_OUTPUTS != 0);

  typedef enum logic [2:0] {
    IDLE, FETCH, SHIFT_HI, SHIFT_LO, LATCH, DISPLAY, NEXT_ROW, NEXT_PLANE
  } state_t;

  state_t                state;
  logic [ROW_ADDR_W-1:0] row, row_q;
  logic [COL_W-1:0]      col;
  logic [PLANE_W-1:0]    plane;
  logic [FCNT_W-1:0]     fcnt;
  logic [WIN_W-1:0]      wcnt;
  logic [7:0]            bright_q;
  logic [ADDR_W-1:0]     addr_q;
  logic                  pclk_q, latch_q, blank_q, done_q;
  logic [2:0]            cp0_q, cp1_q;

  logic [WIN_W-1:0]      win_len, lit_len;
  logic [8:0]            bright_p1;
  logic [PROD_W-1:0]     prod;

  function automatic logic [2:0] plane_bits(input logic [3*BPC-1:0] pix,
                                            input logic [PLANE_W-1:0] p);
    return {pix[2*BPC + int'(p)], pix[BPC + int'(p)], pix[int'(p)]};
  endfunction

  // In LATCH the live brightness is used so the first display cycle is already correct.
  always_comb begin
    win_len   = WIN_W'(BASE_TICKS) << plane;
    bright_p1 = {1'b0, (state == LATCH) ? brightness : bright_q} + 9'd1;
    prod      = PROD_W'(win_len) * PROD_W'(bright_p1);
    lit_len   = WIN_W'(prod >> 8);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      row      <= '0;
      row_q    <= '0;
      col      <= '0;
      plane    <= '0;
      fcnt     <= '0;
      wcnt     <= '0;
      bright_q <= '0;
      addr_q   <= '0;
      pclk_q   <= 1'b0;
      latch_q  <= 1'b0;
      blank_q  <= 1'b1;
      done_q   <= 1'b0;
      cp0_q    <= '0;
      cp1_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          blank_q <= 1'b1;
          if (enable) begin
            state <= FETCH;
            fcnt  <= '0;
          end
        end
        FETCH: begin
          if (fcnt == FCNT_W'(RAM_LATENCY - 1)) begin
            state  <= SHIFT_HI;
            pclk_q <= 1'b1;
            cp0_q  <= plane_bits(pixel0, plane);
            cp1_q  <= plane_bits(pixel1, plane);
          end else begin
            fcnt <= fcnt + 1'b1;
          end
        end
        SHIFT_HI: begin
          // Address advances a cycle early (carrying into the row) so the RAM sees it
          // one edge before FETCH starts counting its latency.
          state  <= SHIFT_LO;
          pclk_q <= 1'b0;
          col    <= col + 1'b1;
          addr_q <= {row, col} + ADDR_W'(1);
        end
        SHIFT_LO: begin
          if (col == '0) begin
            state   <= LATCH;
            latch_q <= 1'b1;
            row_q   <= row;
          end else begin
            state <= FETCH;
            fcnt  <= '0;
          end
        end
        LATCH: begin
          state    <= DISPLAY;
          latch_q  <= 1'b0;
          bright_q <= brightness;
          wcnt     <= '0;
          blank_q  <= (lit_len == '0);
        end
        DISPLAY: begin
          if (wcnt == win_len - WIN_W'(1)) begin
            state   <= NEXT_ROW;
            blank_q <= 1'b1;
          end else begin
            wcnt    <= wcnt + WIN_W'(1);
            blank_q <= (wcnt + WIN_W'(1)) >= lit_len;
          end
        end
        NEXT_ROW: begin
          row  <= row + 1'b1;
          fcnt <= '0;
          if (&row) begin
            state  <= NEXT_PLANE;
            done_q <= (plane == PLANE_W'(BPC - 1));
          end else begin
            state <= FETCH;
          end
        end
        NEXT_PLANE: begin
          done_q <= 1'b0;
          fcnt   <= '0;
          if (plane == PLANE_W'(BPC - 1)) begin
            plane <= '0;
            state <= enable ? FETCH : IDLE;
          end else begin
            plane <= plane + 1'b1;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pixelAddress0 = addr_q;
  assign pixelAddress1 = addr_q;
  assign rowDecoder    = row_q ^ {ROW_ADDR_W{INV}};
  assign pixelClk      = pclk_q ^ INV;
  assign columnLatch   = latch_q ^ INV;
  assign blank         = blank_q ^ INV;
  assign columnPixels0 = cp0_q ^ {3{INV}};
  assign columnPixels1 = cp1_q ^ {3{INV}};
  assign frameDone     = done_q;
endmodule

// File: tb/tb_hub75_bcm_driver.sv
// Scoreboard bench for hub75_bcm_driver: stimulus queues expected shifts, latches, lit
// lengths and frame pulses; a negedge monitor pops and compares as the DUT produces them.
module tb_hub75_bcm_driver;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] brightness = 8'd0;
  logic [2:0] pixelAddress0, pixelAddress1;
  logic [5:0] pixel0 = '0, pixel1 = '0;
  logic [0:0] rowDecoder;
  logic       pixelClk, columnLatch, blank, frameDone;
  logic [2:0] columnPixels0, columnPixels1;

  hub75_bcm_driver #(.COLS(4), .ROW_ADDR_W(1), .BPC(2), .BASE_TICKS(4),
                     .RAM_LATENCY(2), .INVERT_OUTPUTS(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .brightness(brightness),
    .pixelAddress0(pixelAddress0), .pixel0(pixel0),
    .pixelAddress1(pixelAddress1), .pixel1(pixel1),
    .rowDecoder(rowDecoder), .pixelClk(pixelClk),
    .columnPixels0(columnPixels0), .columnPixels1(columnPixels1),
    .columnLatch(columnLatch), .blank(blank), .frameDone(frameDone));

  always #5 clk = ~clk;

  typedef struct packed { logic [2:0] addr; logic [2:0] cp0; logic [2:0] cp1; } shift_t;
  shift_t shift_q[$];
  int     latch_q[$];
  int     lit_q[$];
  int     frame_q[$];
  int     errors = 0, checks = 0, frames_seen = 0;
  int     mode = 0;

  function automatic logic [5:0] ram0(input logic [2:0] a);
    return (mode == 0) ? {3'b000, a} : 6'b10_01_11;
  endfunction
  function automatic logic [5:0] ram1(input logic [2:0] a);
    return (mode == 0) ? ({3'b000, a} ^ 6'b101101) : 6'b01_10_00;
  endfunction
  function automatic logic [2:0] bits(input logic [5:0] pix, input int p);
    return (p == 0) ? {pix[4], pix[2], pix[0]} : {pix[5], pix[3], pix[1]};
  endfunction
  // Hand-computed lit lengths for windows of 4 and 8 cycles.
  function automatic int lit_exp(input int b, input int p);
    case (b)
      255:     return (p == 0) ? 4 : 8;
      127:     return (p == 0) ? 2 : 4;
      default: return 0;
    endcase
  endfunction

  // Two-stage RAM pipeline.
  logic [2:0] a_d = '0;
  always @(posedge clk) begin
    a_d    <= pixelAddress0;
    pixel0 <= ram0(a_d);
    pixel1 <= ram1(a_d);
  end

  task automatic push_frame(input int b);
    shift_t s;
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < 2; r++) begin
        for (int c = 0; c < 4; c++) begin
          s.addr = 3'(r * 4 + c);
          s.cp0  = bits(ram0(s.addr), p);
          s.cp1  = bits(ram1(s.addr), p);
          shift_q.push_back(s);
        end
        latch_q.push_back(r);
        lit_q.push_back(lit_exp(b, p));
      end
    frame_q.push_back(4);
  endtask

  // Monitor state
  int   cyc = 0, shifts = 0, first_p = 0, lit_cnt = 0, latches = 0;
  logic in_win = 0, busy_lit = 0, row_bad = 0, prev_p = 0, prev_fd = 0;
  logic prev_row = 0;

  task automatic close_window();
    int e;
    checks++;
    if (lit_q.size() == 0) begin
      errors++; $display("FAIL lit_window: got %0d cycles, none expected", lit_cnt);
    end else begin
      e = lit_q.pop_front();
      if (lit_cnt != e) begin
        errors++; $display("FAIL lit_window: got %0d lit cycles, expected %0d", lit_cnt, e);
      end
    end
    in_win = 0;
  endtask

  always @(negedge clk) begin
    logic lp, ll, lb, lr;
    shift_t s;
    int e;
    cyc++;
    if (rst) begin
      shifts = 0; lit_cnt = 0; latches = 0; in_win = 0; busy_lit = 0;
      row_bad = 0; prev_p = 0; prev_fd = 0; prev_row = 0;
    end else begin
      lp = ~pixelClk; ll = ~columnLatch; lb = ~blank; lr = ~rowDecoder[0];
      if (in_win && !lb) lit_cnt++;
      if (!lb && (lp || ll)) busy_lit = 1;
      if (lr != prev_row && !ll) row_bad = 1;
      prev_row = lr;
      if (lp && !prev_p) begin
        if (shifts == 0) first_p = cyc;
        shifts++;
        checks++;
        if (shift_q.size() == 0) begin
          errors++; $display("FAIL shift: unexpected pixelClk at addr %0d", pixelAddress0);
        end else begin
          s = shift_q.pop_front();
          if (pixelAddress0 !== s.addr || pixelAddress1 !== s.addr ||
              (~columnPixels0) !== s.cp0 || (~columnPixels1) !== s.cp1) begin
            errors++;
            $display("FAIL shift: addr=%0d/%0d cp0=%b cp1=%b, expected addr=%0d cp0=%b cp1=%b",
                     pixelAddress0, pixelAddress1, ~columnPixels0, ~columnPixels1,
                     s.addr, s.cp0, s.cp1);
          end
        end
      end
      prev_p = lp;
      if (ll) begin
        if (in_win) close_window();
        checks++;
        if (latch_q.size() == 0) begin
          errors++; $display("FAIL latch: unexpected latch row=%0d", lr);
        end else begin
          e = latch_q.pop_front();
          if (int'(lr) != e || shifts != 4 || cyc - first_p != 14) begin
            errors++;
            $display("FAIL latch: row=%0d shifts=%0d span=%0d, expected row=%0d shifts=4 span=14",
                     lr, shifts, cyc - first_p, e);
          end
        end
        shifts = 0; latches++; in_win = 1; lit_cnt = 0;
      end
      if (frameDone) begin
        if (in_win) close_window();
        checks++;
        if (frame_q.size() == 0) begin
          errors++; $display("FAIL frame_done: unexpected pulse");
        end else begin
          e = frame_q.pop_front();
          if (latches != e || busy_lit || row_bad || prev_fd) begin
            errors++;
            $display("FAIL frame_done: latches=%0d busy_lit=%0d row_bad=%0d double=%0d, expected %0d/0/0/0",
                     latches, busy_lit, row_bad, prev_fd, e);
          end
        end
        frames_seen++; latches = 0; busy_lit = 0; row_bad = 0;
      end
      prev_fd = frameDone;
    end
  end

  task automatic check_reset(input string name);
    logic [13:0] got;
    got = {blank, pixelClk, columnLatch, columnPixels0, columnPixels1, rowDecoder,
           frameDone, pixelAddress0};
    checks++;
    if (got !== 14'b0_1_1_111_111_1_0_000) begin
      errors++; $display("FAIL %s: pins=%b expected 01111111110000", name, got);
    end
  endtask

  task automatic idle_check(input int n, input string name);
    int lit = 0, pc = 0;
    repeat (n) begin
      @(negedge clk);
      if (blank !== 1'b0) lit++;
      if (pixelClk !== 1'b1) pc++;
    end
    checks++;
    if (lit != 0 || pc != 0) begin
      errors++; $display("FAIL %s: lit=%0d pclk=%0d, expected 0/0", name, lit, pc);
    end
  endtask

  task automatic wait_frames(input int target, input int limit);
    int n = 0;
    while (frames_seen < target && n < limit) begin
      @(negedge clk); n++;
    end
    if (frames_seen < target) begin
      checks++; errors++;
      $display("FAIL frame_timeout: frames=%0d expected %0d", frames_seen, target);
    end
  endtask

  task automatic run_one(input int m, input int b, input int target);
    mode = m; brightness = 8'(b);
    push_frame(b);
    enable = 1'b1;
    repeat (5) @(negedge clk);
    enable = 1'b0;
    wait_frames(target, 400);
  endtask

  initial begin
    int n;
    #1 rst = 1'b1;
    #2 check_reset("reset_state");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_check(20, "idle_no_enable");

    // Two back-to-back frames at full brightness, enable dropped mid second frame.
    mode = 0; brightness = 8'd255;
    push_frame(255); push_frame(255);
    enable = 1'b1;
    wait_frames(1, 400);
    repeat (10) @(negedge clk);
    enable = 1'b0;
    wait_frames(2, 400);
    idle_check(30, "idle_after_drop");

    run_one(1, 127, 3);
    run_one(0, 0, 4);
    idle_check(10, "idle_after_dark");

    // Reset while pixelClk is high, then a clean restart from address 0, plane 0.
    mode = 0; brightness = 8'd255;
    push_frame(255);
    enable = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (pixelClk !== 1'b0 && n < 200);
    enable = 1'b0;
    if (pixelClk !== 1'b0) begin
      checks++; errors++; $display("FAIL shift_wait: pixelClk=%b expected 0", pixelClk);
    end
    #1 rst = 1'b1;
    #1 check_reset("reset_async");
    shift_q.delete(); latch_q.delete(); lit_q.delete(); frame_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_one(0, 255, 5);

    repeat (5) @(negedge clk);
    checks++;
    if (shift_q.size() + latch_q.size() + lit_q.size() + frame_q.size() != 0) begin
      errors++;
      $display("FAIL drain: shifts=%0d latches=%0d lits=%0d frames=%0d left, expected 0",
               shift_q.size(), latch_q.size(), lit_q.size(), frame_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
